// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register slice.
//   `INST_ID_LEN   : width of the control-unit instruction identifier
//   `On / `Off     : single-bit enable literals
//   XLEN_DEFAULT   : default datapath width
//   REG_AW_DEFAULT : default register-address width
//   instrId_e      : recognised instruction identifiers
//   isKnownInstr() : true for identifiers the control unit can produce
// Optional feature macro (used by id_ex_stage): ID_EX_LOAD_USE_INTERLOCK_EN
// ---------------------------------------------------------------------------
`ifndef ID_EX_STAGE_DEFINES
`define ID_EX_STAGE_DEFINES
`define INST_ID_LEN 6
`define On  1'b1
`define Off 1'b0
`endif

package id_ex_stage_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;

  // Identifiers above INST_JAL are not produced by a healthy control unit.
  typedef enum logic [`INST_ID_LEN-1:0] {
    INST_NOP  = 6'd0,
    INST_ADD  = 6'd1,
    INST_SUB  = 6'd2,
    INST_AND  = 6'd3,
    INST_OR   = 6'd4,
    INST_ADDI = 6'd5,
    INST_LW   = 6'd6,
    INST_SW   = 6'd7,
    INST_BEQ  = 6'd8,
    INST_JAL  = 6'd9
  } instrId_e;

  localparam logic [`INST_ID_LEN-1:0] INST_ID_LAST = INST_JAL;

  // Unrecognised identifiers still flow down the pipe, but with their
  // side-effect enables stripped so they behave as harmless no-ops.
  function automatic logic isKnownInstr(input logic [`INST_ID_LEN-1:0] id);
    return (id <= INST_ID_LAST);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use comparator: flags an instruction in decode that
// reads the destination of a load currently held in the EX register.
// Ports:
//   i_exValid, i_exMemRe, i_exRdAddr : instruction held in the EX register
//   i_idValid, i_rs1Re, i_rs2Re,
//   i_rs1Addr, i_rs2Addr             : instruction waiting in decode
//   o_loadUse                        : hazard flag
// ---------------------------------------------------------------------------
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              i_exValid,
  input  logic              i_exMemRe,
  input  logic [REG_AW-1:0] i_exRdAddr,
  input  logic              i_idValid,
  input  logic              i_rs1Re,
  input  logic              i_rs2Re,
  input  logic [REG_AW-1:0] i_rs1Addr,
  input  logic [REG_AW-1:0] i_rs2Addr,
  output logic              o_loadUse
);

  logic w_rs1Hit;
  logic w_rs2Hit;

  assign w_rs1Hit = i_rs1Re && (i_rs1Addr == i_exRdAddr);
  assign w_rs2Hit = i_rs2Re && (i_rs2Addr == i_exRdAddr);

  // x0 is hard-wired to zero, so a load targeting it can never be a hazard.
  assign o_loadUse = i_exValid && i_exMemRe && (i_exRdAddr != '0) &&
                     i_idValid && (w_rs1Hit || w_rs2Hit);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with flush, back-pressure hold and an optional
// load-use interlock that inserts a bubble and counts stalls.
// Configuration macro: ID_EX_LOAD_USE_INTERLOCK_EN
//   defined   : hazard_detect drives load_use_o, bubbles counted in stall_cnt_o
//   undefined : load_use_o = 0, stall_cnt_o = 0, no counter flops
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   id_valid_i / id_ready_o      : decode handshake
//   id_pc_i, id_imm_i, id_instr_id_i, id_*_re_i/we_i, id_*_addr_i,
//   id_rs*_data_i                : decoded instruction fields
//   flush_i                      : redirect, kills decode and EX register
//   ex_ready_i                   : EX consumes the held instruction
//   ex_*_o                       : registered instruction fields for EX
//   load_use_o                   : combinational load-use hazard flag
//   stall_cnt_o                  : wrapping count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid_i,
  output logic                    id_ready_o,
  input  logic [XLEN-1:0]         id_pc_i,
  input  logic [XLEN-1:0]         id_imm_i,
  input  logic [`INST_ID_LEN-1:0] id_instr_id_i,
  input  logic                    id_rs1_re_i,
  input  logic                    id_rs2_re_i,
  input  logic                    id_rd_we_i,
  input  logic                    id_mem_re_i,
  input  logic                    id_mem_we_i,
  input  logic [REG_AW-1:0]       id_rs1_addr_i,
  input  logic [REG_AW-1:0]       id_rs2_addr_i,
  input  logic [REG_AW-1:0]       id_rd_addr_i,
  input  logic [XLEN-1:0]         id_rs1_data_i,
  input  logic [XLEN-1:0]         id_rs2_data_i,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  output logic                    ex_valid_o,
  output logic [XLEN-1:0]         ex_pc_o,
  output logic [XLEN-1:0]         ex_imm_o,
  output logic [XLEN-1:0]         ex_rs1_data_o,
  output logic [XLEN-1:0]         ex_rs2_data_o,
  output logic [`INST_ID_LEN-1:0] ex_instr_id_o,
  output logic [REG_AW-1:0]       ex_rd_addr_o,
  output logic                    ex_rd_we_o,
  output logic                    ex_mem_re_o,
  output logic                    ex_mem_we_o,
  output logic                    load_use_o,
  output logic [31:0]             stall_cnt_o
);

  logic                    r_exValid;
  logic [XLEN-1:0]         r_exPc;
  logic [XLEN-1:0]         r_exImm;
  logic [XLEN-1:0]         r_exRs1Data;
  logic [XLEN-1:0]         r_exRs2Data;
  logic [`INST_ID_LEN-1:0] r_exInstrId;
  logic [REG_AW-1:0]       r_exRdAddr;
  logic                    r_exRdWe;
  logic                    r_exMemRe;
  logic                    r_exMemWe;

  logic w_loadUse;
  logic w_hold;
  logic w_known;

`ifdef ID_EX_LOAD_USE_INTERLOCK_EN
  logic [31:0] r_stallCnt;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazardDetect (
    .i_exValid  (r_exValid),
    .i_exMemRe  (r_exMemRe),
    .i_exRdAddr (r_exRdAddr),
    .i_idValid  (id_valid_i),
    .i_rs1Re    (id_rs1_re_i),
    .i_rs2Re    (id_rs2_re_i),
    .i_rs1Addr  (id_rs1_addr_i),
    .i_rs2Addr  (id_rs2_addr_i),
    .o_loadUse  (w_loadUse)
  );

  // A bubble is only inserted when the EX register is free to change, so
  // the counter steps exactly on edges where the hazard costs a cycle.
  // The counter wraps naturally; it is a diagnostic, not a limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else if (!flush_i && !w_hold && w_loadUse) begin
      r_stallCnt <= r_stallCnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stallCnt;
`else
  // Without the interlock the compiler schedules around load-use hazards,
  // so the source-register fields are intentionally left unobserved.
  logic w_unusedHazardIns;

  assign w_unusedHazardIns = ^{id_rs1_re_i, id_rs2_re_i, id_rs1_addr_i, id_rs2_addr_i};
  assign w_loadUse         = `Off;
  assign stall_cnt_o       = '0;
`endif

  assign w_hold     = r_exValid && !ex_ready_i;
  assign w_known    = isKnownInstr(id_instr_id_i);
  assign load_use_o = w_loadUse;

  // A flush always accepts (and drops) the decode instruction.
  assign id_ready_o = flush_i || ((!r_exValid || ex_ready_i) && !w_loadUse);

  // Priority: flush, hold, bubble, load, idle. Every path that leaves the
  // register empty also clears the side-effect enables so an invalid slot
  // can never write the register file or memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exValid   <= `Off;
      r_exPc      <= '0;
      r_exImm     <= '0;
      r_exRs1Data <= '0;
      r_exRs2Data <= '0;
      r_exInstrId <= '0;
      r_exRdAddr  <= '0;
      r_exRdWe    <= `Off;
      r_exMemRe   <= `Off;
      r_exMemWe   <= `Off;
    end else if (flush_i) begin
      r_exValid <= `Off;
      r_exRdWe  <= `Off;
      r_exMemRe <= `Off;
      r_exMemWe <= `Off;
    end else if (!w_hold) begin
      if (!w_loadUse && id_valid_i) begin
        r_exValid   <= `On;
        r_exPc      <= id_pc_i;
        r_exImm     <= id_imm_i;
        r_exRs1Data <= id_rs1_data_i;
        r_exRs2Data <= id_rs2_data_i;
        r_exInstrId <= id_instr_id_i;
        r_exRdAddr  <= id_rd_addr_i;
        r_exRdWe    <= id_rd_we_i  && w_known;
        r_exMemRe   <= id_mem_re_i && w_known;
        r_exMemWe   <= id_mem_we_i && w_known;
      end else begin
        r_exValid <= `Off;
        r_exRdWe  <= `Off;
        r_exMemRe <= `Off;
        r_exMemWe <= `Off;
      end
    end
  end

  assign ex_valid_o    = r_exValid;
  assign ex_pc_o       = r_exPc;
  assign ex_imm_o      = r_exImm;
  assign ex_rs1_data_o = r_exRs1Data;
  assign ex_rs2_data_o = r_exRs2Data;
  assign ex_instr_id_o = r_exInstrId;
  assign ex_rd_addr_o  = r_exRdAddr;
  assign ex_rd_we_o    = r_exRdWe;
  assign ex_mem_re_o   = r_exMemRe;
  assign ex_mem_we_o   = r_exMemWe;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios plus a randomized run against a transaction-level
// model of the ID/EX slot. Works with or without
// ID_EX_LOAD_USE_INTERLOCK_EN; expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

`ifdef ID_EX_LOAD_USE_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid_i, id_ready_o;
  logic [31:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i;
  logic [`INST_ID_LEN-1:0] id_instr_id_i;
  logic id_rs1_re_i, id_rs2_re_i, id_rd_we_i, id_mem_re_i, id_mem_we_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic flush_i, ex_ready_i;
  logic ex_valid_o;
  logic [31:0] ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o;
  logic [`INST_ID_LEN-1:0] ex_instr_id_o;
  logic [4:0] ex_rd_addr_o;
  logic ex_rd_we_o, ex_mem_re_o, ex_mem_we_o, load_use_o;
  logic [31:0] stall_cnt_o;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_instr_id_i(id_instr_id_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i), .id_rd_we_i(id_rd_we_i),
    .id_mem_re_i(id_mem_re_i), .id_mem_we_i(id_mem_we_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_instr_id_o(ex_instr_id_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_rd_we_o(ex_rd_we_o), .ex_mem_re_o(ex_mem_re_o), .ex_mem_we_o(ex_mem_we_o),
    .load_use_o(load_use_o), .stall_cnt_o(stall_cnt_o)
  );

  // -------------------------------------------------------------------------
  // Reference model: one slot holding the instruction EX will see, plus the
  // bubble tally. Decisions follow the stage's documented rules directly.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic                    valid;
    logic [31:0]             pc;
    logic [31:0]             imm;
    logic [31:0]             rs1;
    logic [31:0]             rs2;
    logic [`INST_ID_LEN-1:0] id;
    logic [4:0]              rd;
    logic                    rdWe;
    logic                    memRe;
    logic                    memWe;
  } slot_t;

  slot_t       mSlot;
  logic [31:0] mCnt;
  logic        mLoadUse;
  logic        mReady;

  always_comb begin
    mLoadUse = INTERLOCK && mSlot.valid && mSlot.memRe && (mSlot.rd != 5'd0) && id_valid_i &&
               ((id_rs1_re_i && id_rs1_addr_i == mSlot.rd) || (id_rs2_re_i && id_rs2_addr_i == mSlot.rd));
    mReady   = flush_i || ((!mSlot.valid || ex_ready_i) && !mLoadUse);
  end

  function automatic slot_t decodeSlot();
    slot_t s;
    logic  known;
    known   = (id_instr_id_i <= INST_JAL);
    s.valid = 1'b1;
    s.pc    = id_pc_i;
    s.imm   = id_imm_i;
    s.rs1   = id_rs1_data_i;
    s.rs2   = id_rs2_data_i;
    s.id    = id_instr_id_i;
    s.rd    = id_rd_addr_i;
    s.rdWe  = known & id_rd_we_i;
    s.memRe = known & id_mem_re_i;
    s.memWe = known & id_mem_we_i;
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mSlot <= '0;
      mCnt  <= '0;
    end else if (flush_i) begin
      mSlot <= '0;
    end else if (mSlot.valid && !ex_ready_i) begin
      mSlot <= mSlot;
    end else if (mLoadUse) begin
      mSlot <= '0;
      mCnt  <= mCnt + 32'd1;
    end else if (id_valid_i) begin
      mSlot <= decodeSlot();
    end else begin
      mSlot <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic driveIdle();
    id_valid_i = 0; id_pc_i = 0; id_imm_i = 0; id_instr_id_i = 0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; id_rd_we_i = 0; id_mem_re_i = 0; id_mem_we_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
    id_rs1_data_i = 0; id_rs2_data_i = 0; flush_i = 0; ex_ready_i = 1;
  endtask

  task automatic applyStimulus(input logic [`INST_ID_LEN-1:0] id, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic rs1Re, input logic rs2Re, input logic rdWe,
                               input logic memRe, input logic memWe, input logic [31:0] imm);
    id_valid_i = 1; id_instr_id_i = id; id_rd_addr_i = rd;
    id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rs1_re_i = rs1Re; id_rs2_re_i = rs2Re;
    id_rd_we_i = rdWe; id_mem_re_i = memRe; id_mem_we_i = memWe; id_imm_i = imm;
    id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    driveIdle();
    #1 rst = 1;
    #1;
    nCompared++; if (ex_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got=%0b exp=0", ex_valid_o); end
    nCompared++; if (ex_pc_o !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_pc got=%h exp=0", ex_pc_o); end
    nCompared++; if ({ex_rd_we_o, ex_mem_re_o, ex_mem_we_o} !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_enables got=%b exp=000", {ex_rd_we_o, ex_mem_re_o, ex_mem_we_o}); end
    nCompared++; if (stall_cnt_o !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_stall_cnt got=%0d exp=0", stall_cnt_o); end
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    nCompared++; if (ex_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_idle_valid got=%0b exp=0", ex_valid_o); end
  endtask

  task automatic test_addi();
    @(negedge clk);
    applyStimulus(INST_ADDI, 5'd1, 5'd0, 5'd0, 1, 0, 1, 0, 0, 32'h0000_0123);
    #1;
    nCompared++; if (id_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_ready got=%0b exp=1", id_ready_o); end
    @(negedge clk);
    driveIdle();
    nCompared++; if (ex_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_valid got=%0b exp=1", ex_valid_o); end
    nCompared++; if (ex_rd_addr_o !== 5'd1) begin nMismatched++; $display("[TB] FAIL addi_rd got=%0d exp=1", ex_rd_addr_o); end
    nCompared++; if (ex_rd_we_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_rd_we got=%0b exp=1", ex_rd_we_o); end
    nCompared++; if (ex_imm_o !== 32'h0000_0123) begin nMismatched++; $display("[TB] FAIL addi_imm got=%h exp=00000123", ex_imm_o); end
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    @(negedge clk);
    applyStimulus(INST_LW, 5'd5, 5'd2, 5'd0, 1, 0, 1, 1, 0, 32'h8);
    @(negedge clk);
    base = mCnt;
    nCompared++; if (ex_mem_re_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL lu_lw_mem_re got=%0b exp=1", ex_mem_re_o); end
    applyStimulus(INST_ADD, 5'd6, 5'd5, 5'd7, 1, 1, 1, 0, 0, 32'h0);
    #1;
    nCompared++; if (load_use_o !== INTERLOCK) begin nMismatched++; $display("[TB] FAIL lu_flag got=%0b exp=%0b", load_use_o, INTERLOCK); end
    nCompared++; if (id_ready_o !== !INTERLOCK) begin nMismatched++; $display("[TB] FAIL lu_ready got=%0b exp=%0b", id_ready_o, !INTERLOCK); end
    @(negedge clk);
    nCompared++; if (ex_valid_o !== !INTERLOCK) begin nMismatched++; $display("[TB] FAIL lu_bubble_valid got=%0b exp=%0b", ex_valid_o, !INTERLOCK); end
    nCompared++; if (stall_cnt_o !== base + 32'(INTERLOCK)) begin nMismatched++; $display("[TB] FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt_o, base + 32'(INTERLOCK)); end
    #1;
    nCompared++; if (id_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL lu_ready_after got=%0b exp=1", id_ready_o); end
    @(negedge clk);
    driveIdle();
    nCompared++; if (ex_valid_o !== 1'b1 || ex_rd_addr_o !== 5'd6) begin nMismatched++; $display("[TB] FAIL lu_add_issue got=%0b/%0d exp=1/6", ex_valid_o, ex_rd_addr_o); end
  endtask

  task automatic test_x0();
    logic [31:0] base;
    @(negedge clk);
    applyStimulus(INST_LW, 5'd0, 5'd3, 5'd0, 1, 0, 1, 1, 0, 32'h4);
    @(negedge clk);
    base = mCnt;
    applyStimulus(INST_ADD, 5'd6, 5'd0, 5'd0, 1, 1, 1, 0, 0, 32'h0);
    #1;
    nCompared++; if (load_use_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL x0_flag got=%0b exp=0", load_use_o); end
    nCompared++; if (id_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL x0_ready got=%0b exp=1", id_ready_o); end
    @(negedge clk);
    driveIdle();
    nCompared++; if (ex_valid_o !== 1'b1 || ex_rd_addr_o !== 5'd6) begin nMismatched++; $display("[TB] FAIL x0_issue got=%0b/%0d exp=1/6", ex_valid_o, ex_rd_addr_o); end
    nCompared++; if (stall_cnt_o !== base) begin nMismatched++; $display("[TB] FAIL x0_stall_cnt got=%0d exp=%0d", stall_cnt_o, base); end
  endtask

  task automatic test_hold();
    logic [31:0] pcSw;
    @(negedge clk);
    applyStimulus(INST_SW, 5'd0, 5'd2, 5'd3, 1, 1, 0, 0, 1, 32'h40);
    pcSw = id_pc_i;
    @(negedge clk);
    ex_ready_i = 0;
    applyStimulus(INST_ADDI, 5'd3, 5'd1, 5'd0, 1, 0, 1, 0, 0, 32'h7);
    for (int c = 0; c < 3; c++) begin
      #1;
      nCompared++; if (id_ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_ready cyc=%0d got=%0b exp=0", c, id_ready_o); end
      @(negedge clk);
      nCompared++;
      if (ex_valid_o !== 1'b1 || ex_mem_we_o !== 1'b1 || ex_pc_o !== pcSw || ex_imm_o !== 32'h40) begin
        nMismatched++;
        $display("[TB] FAIL hold_stable cyc=%0d got=%0b/%0b/%h/%h exp=1/1/%h/00000040", c, ex_valid_o, ex_mem_we_o, ex_pc_o, ex_imm_o, pcSw);
      end
    end
    ex_ready_i = 1;
    #1;
    nCompared++; if (id_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_release_ready got=%0b exp=1", id_ready_o); end
    @(negedge clk);
    driveIdle();
    nCompared++;
    if (ex_rd_addr_o !== 5'd3 || ex_rd_we_o !== 1'b1 || ex_mem_we_o !== 1'b0 || ex_imm_o !== 32'h7) begin
      nMismatched++;
      $display("[TB] FAIL hold_next_load got=%0d/%0b/%0b/%h exp=3/1/0/00000007", ex_rd_addr_o, ex_rd_we_o, ex_mem_we_o, ex_imm_o);
    end
  endtask

  task automatic test_flush_stall();
    logic [31:0] base;
    @(negedge clk);
    applyStimulus(INST_LW, 5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 0, 32'h10);
    @(negedge clk);
    base = mCnt;
    applyStimulus(INST_ADD, 5'd6, 5'd5, 5'd7, 1, 1, 1, 0, 0, 32'h0);
    flush_i = 1;
    #1;
    nCompared++; if (load_use_o !== INTERLOCK) begin nMismatched++; $display("[TB] FAIL flush_flag got=%0b exp=%0b", load_use_o, INTERLOCK); end
    nCompared++; if (id_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_ready got=%0b exp=1", id_ready_o); end
    @(negedge clk);
    driveIdle();
    nCompared++; if (ex_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_valid got=%0b exp=0", ex_valid_o); end
    nCompared++; if ({ex_rd_we_o, ex_mem_re_o, ex_mem_we_o} !== 3'b000) begin nMismatched++; $display("[TB] FAIL flush_enables got=%b exp=000", {ex_rd_we_o, ex_mem_re_o, ex_mem_we_o}); end
    nCompared++; if (stall_cnt_o !== base) begin nMismatched++; $display("[TB] FAIL flush_stall_cnt got=%0d exp=%0d", stall_cnt_o, base); end
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    applyStimulus(INST_SW, 5'd0, 5'd4, 5'd5, 1, 1, 0, 0, 1, 32'h99);
    @(negedge clk);
    driveIdle();
    ex_ready_i = 0;
    @(negedge clk);
    nCompared++; if (ex_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL rsthold_held got=%0b exp=1", ex_valid_o); end
    #2 rst = 1;
    #1;
    nCompared++;
    if (ex_valid_o !== 1'b0 || ex_mem_we_o !== 1'b0 || ex_pc_o !== 32'd0 || ex_imm_o !== 32'd0 || ex_rs1_data_o !== 32'd0 || ex_rs2_data_o !== 32'd0) begin
      nMismatched++;
      $display("[TB] FAIL rsthold_clear got=%0b/%0b/%h/%h/%h/%h exp=all zero", ex_valid_o, ex_mem_we_o, ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o);
    end
    nCompared++; if (stall_cnt_o !== 32'd0 || load_use_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rsthold_cnt got=%0d/%0b exp=0/0", stall_cnt_o, load_use_o); end
    @(negedge clk);
    rst = 0;
    ex_ready_i = 1;
    @(negedge clk);
    nCompared++; if (ex_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rsthold_idle got=%0b exp=0", ex_valid_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      nCompared++;
      if (ex_valid_o !== mSlot.valid || {ex_rd_we_o, ex_mem_re_o, ex_mem_we_o} !== {mSlot.rdWe, mSlot.memRe, mSlot.memWe} || stall_cnt_o !== mCnt) begin
        nMismatched++;
        $display("[TB] FAIL rand_ctrl n=%0d got=%0b/%b/%0d exp=%0b/%b/%0d", n, ex_valid_o,
                 {ex_rd_we_o, ex_mem_re_o, ex_mem_we_o}, stall_cnt_o, mSlot.valid, {mSlot.rdWe, mSlot.memRe, mSlot.memWe}, mCnt);
      end
      if (mSlot.valid) begin
        nCompared++;
        if ({ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_instr_id_o, ex_rd_addr_o} !==
            {mSlot.pc, mSlot.imm, mSlot.rs1, mSlot.rs2, mSlot.id, mSlot.rd}) begin
          nMismatched++;
          $display("[TB] FAIL rand_payload n=%0d got=%h/%h/%0d/%0d exp=%h/%h/%0d/%0d", n, ex_pc_o, ex_imm_o,
                   ex_instr_id_o, ex_rd_addr_o, mSlot.pc, mSlot.imm, mSlot.id, mSlot.rd);
        end
      end
      applyStimulus(6'($urandom_range(0, 12)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), $urandom);
      id_valid_i = ($urandom_range(0, 4) != 0);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 11) == 0);
      #1;
      nCompared++;
      if (load_use_o !== mLoadUse || id_ready_o !== mReady) begin
        nMismatched++;
        $display("[TB] FAIL rand_comb n=%0d got=%0b/%0b exp=%0b/%0b", n, load_use_o, id_ready_o, mLoadUse, mReady);
      end
    end
    @(negedge clk);
    driveIdle();
  endtask

  initial begin
    driveIdle();
    test_reset();
    test_addi();
    test_load_use();
    test_x0();
    test_hold();
    test_flush_stall();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: XLEN, default 32, datapath width; REG_AW, default 5, register-address width.
REQ-002 clk  input  1  rising-edge clock; rst  input  1  asynchronous, active-high reset.
REQ-003 id_valid_i  input  1  decode holds a valid instruction; id_ready_o  output  1  stage accepts it this cycle.
REQ-004 id_pc_i  input  XLEN  instruction PC; id_imm_i  input  XLEN  decoded immediate.
REQ-005 id_instr_id_i  input  `INST_ID_LEN  instruction identifier from the control unit.
REQ-006 id_rs1_re_i, id_rs2_re_i, id_rd_we_i, id_mem_re_i, id_mem_we_i  input  1 each  control-unit enables.
REQ-007 id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  input  REG_AW  register addresses.
REQ-008 id_rs1_data_i, id_rs2_data_i  input  XLEN  register-file read data.
REQ-009 flush_i  input  1  branch/jump redirect kills the decode and EX-register instructions.
REQ-010 ex_ready_i  input  1  EX consumes the held instruction this cycle.
REQ-011 ex_valid_o  output  1; ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o  output  XLEN; ex_instr_id_o  output  `INST_ID_LEN; ex_rd_addr_o  output  REG_AW; ex_rd_we_o, ex_mem_re_o, ex_mem_we_o  output  1. All are registered copies.
REQ-012 load_use_o  output  1  combinational hazard flag; stall_cnt_o  output  32  count of load-use bubbles.

Function
REQ-013 Decode-to-register transfer occurs when id_valid_i && id_ready_o; EX drain occurs when ex_valid_o && ex_ready_i.
REQ-014 load_use_o = ex_valid_o && ex_mem_re_o && ex_rd_addr_o!=0 && id_valid_i && ((id_rs1_re_i && id_rs1_addr_i==ex_rd_addr_o) || (id_rs2_re_i && id_rs2_addr_i==ex_rd_addr_o)).
REQ-015 id_ready_o = flush_i || ((!ex_valid_o || ex_ready_i) && !load_use_o).
REQ-016 Priority at each edge: flush_i, then hold, then bubble, then load.
REQ-017 Flush: ex_valid_o<=0; the decode instruction is accepted and discarded; payload is don't-care.
REQ-018 Hold: ex_valid_o && !ex_ready_i: all ex_* outputs keep their values.
REQ-019 Bubble: load_use_o && (!ex_valid_o || ex_ready_i): ex_valid_o<=0, ex_rd_we_o<=0, ex_mem_re_o<=0, ex_mem_we_o<=0; stall_cnt_o increments.
REQ-020 Load: when a transfer occurs, all id_* fields are latched into ex_*, and ex_valid_o<=1, with one-cycle latency.
REQ-021 Idle: no transfer and no hold: ex_valid_o<=0.
REQ-022 Whenever ex_valid_o=0, ex_rd_we_o, ex_mem_re_o and ex_mem_we_o shall be 0.
REQ-023 An unrecognised instruction_id passes through with all enables 0; the stage does not trap.
REQ-024 stall_cnt_o wraps from 0xFFFFFFFF to 0 and never saturates.
REQ-025 rd address 0 never causes a hazard.

Reset
REQ-026 rst asserted asynchronously forces ex_valid_o=0, all other ex_* outputs=0, and stall_cnt_o=0.
REQ-027 When reset asserts mid-stall or mid-hold, the pending instruction is dropped; the first edge after deassertion behaves as Idle or Load.

Configuration
REQ-028 Macro ID_EX_LOAD_USE_INTERLOCK_EN.
REQ-029 When the macro is defined, REQ-014, REQ-019 and the stall counter apply.
REQ-030 When the macro is undefined, load_use_o is tied to 0, stall_cnt_o is tied to 0 with no counter flops, and the compiler is responsible for load-use scheduling.

Structure
REQ-031 The shared package/define file holds the following, none of which are redefined locally:
- `INST_ID_LEN;
- the instruction-ID constants;
- `On/`Off;
- XLEN and REG_AW defaults.
REQ-032 The combinational comparator of REQ-014 lives in sub-module hazard_detect, instantiated once.

Verification
REQ-033 Test 1: ADDI x1 id_valid_i=1, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_rd_addr_o=1, ex_rd_we_o=1, ex_imm_o=the immediate.
REQ-034 Test 2: LW x5 in EX followed by ADD x6,x5,x7 in ID -> load_use_o=1, id_ready_o=0, one bubble with ex_valid_o=0, ADD issued the cycle after, stall_cnt_o=1.
REQ-035 Test 3: LW x0 in EX followed by ADD reading x0 -> load_use_o=0 and no bubble.
REQ-036 Test 4: ex_ready_i=0 for 3 cycles with a valid SW held -> outputs stable and id_ready_o=0; ex_ready_i=1 -> the next instruction loads.
REQ-037 Test 5: flush_i=1 during a load-use stall -> ex_valid_o=0, id_ready_o=1, stall_cnt_o unchanged.
REQ-038 Test 6: reset asserted mid-hold -> all outputs 0 immediately without a clock edge; with the macro undefined, Test 2 yields no bubble.
